mpsoc_sysid_checker: RTL and testbench

Avalon-MM read master that interrogates a system-ID slave after reset or on software request. On a `start` pulse it reads the ID word (word 0) and the timestamp word (word 1), compares both against build-time expected values, and reports match, mismatch or timeout. It sits beside each processor tile in the MPSoC as a hardware guard against loading software built for a different system image.

---
 rtl/mpsoc_sysid_checker.sv | 174 +++++++++++++++++
 tb/tb_mpsoc_sysid_checker.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mpsoc_sysid_checker.sv
// mpsoc_sysid_checker
//   Avalon-MM read master that checks a system-ID slave. A start pulse reads
//   word 0 (ID) and word 1 (build timestamp). Both words are compared with the
//   build-time values, and the block reports match, mismatch or a stalled slave.
//
// Ports
//   clock, reset_n      single clock, synchronous active-low reset
//   start               one-cycle check request (ignored while busy)
//   address, read       registered Avalon master request
//   waitrequest         slave stall
//   readdata            slave data, taken when read && !waitrequest
//   busy                check in progress (read phases and report cycle)
//   done                one-cycle completion pulse
//   id_ok, ts_ok        captured words equal the expected values
//   timeout             a read stalled past TIMEOUT_CYCLES
//   id_value, ts_value  captured words (held until the next accepted start)
module mpsoc_sysid_checker #(
  parameter int unsigned       ADDR_W             = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR          = '0,
  parameter logic [31:0]       EXPECTED_ID        = 32'd0,
  parameter logic [31:0]       EXPECTED_TIMESTAMP = 32'd1766737846,
  parameter int unsigned       TIMEOUT_CYCLES     = 255
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  input  logic              waitrequest,
  input  logic [31:0]       readdata,
  output logic              busy,
  output logic              done,
  output logic              id_ok,
  output logic              ts_ok,
  output logic              timeout,
  output logic [31:0]       id_value,
  output logic [31:0]       ts_value
);

  // Timestamp address wraps modulo 2^ADDR_W.
  localparam logic [ADDR_W-1:0] TS_ADDR = BASE_ADDR + ADDR_W'(4);
  localparam logic [15:0]       TO_LIM  = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_RD_ID, S_RD_TS, S_REPORT} state_t;

  state_t            r_state, w_state;
  logic [15:0]       r_stall, w_stall;
  logic              r_read, w_read;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic              r_busy, w_busy;
  logic              r_done, w_done;
  logic              r_id_ok, w_id_ok;
  logic              r_ts_ok, w_ts_ok;
  logic              r_timeout, w_timeout;
  logic [31:0]       r_id_value, w_id_value;
  logic [31:0]       r_ts_value, w_ts_value;

  // A stall that has already lasted TIMEOUT_CYCLES cycles and is still
  // asserted is the (TIMEOUT_CYCLES+1)-th stalled cycle: abandon the read.
  logic w_expired;
  assign w_expired = waitrequest && (r_stall == TO_LIM);

  // Next-state and next-output logic. The request outputs are computed for
  // the state being entered so that read/address come straight from flops.
  always_comb begin
    w_state    = r_state;
    w_stall    = r_stall;
    w_read     = 1'b0;
    w_addr     = '0;
    w_busy     = 1'b0;
    w_done     = 1'b0;
    w_id_ok    = r_id_ok;
    w_ts_ok    = r_ts_ok;
    w_timeout  = r_timeout;
    w_id_value = r_id_value;
    w_ts_value = r_ts_value;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state    = S_RD_ID;
          w_stall    = '0;
          w_id_ok    = 1'b0;
          w_ts_ok    = 1'b0;
          w_timeout  = 1'b0;
          w_id_value = '0;
          w_ts_value = '0;
          w_read     = 1'b1;
          w_addr     = BASE_ADDR;
          w_busy     = 1'b1;
        end
      end
      S_RD_ID: begin
        w_busy = 1'b1;
        if (!waitrequest) begin
          w_state    = S_RD_TS;
          w_id_value = readdata;
          w_id_ok    = (readdata == EXPECTED_ID);
          w_stall    = '0;
          w_read     = 1'b1;
          w_addr     = TS_ADDR;
        end else if (w_expired) begin
          w_state   = S_REPORT;
          w_timeout = 1'b1;
          w_done    = 1'b1;
        end else begin
          w_stall = r_stall + 16'd1;
          w_read  = 1'b1;
          w_addr  = BASE_ADDR;
        end
      end
      S_RD_TS: begin
        w_busy = 1'b1;
        if (!waitrequest) begin
          w_state    = S_REPORT;
          w_ts_value = readdata;
          w_ts_ok    = (readdata == EXPECTED_TIMESTAMP);
          w_done     = 1'b1;
        end else if (w_expired) begin
          w_state   = S_REPORT;
          w_timeout = 1'b1;
          w_done    = 1'b1;
        end else begin
          w_stall = r_stall + 16'd1;
          w_read  = 1'b1;
          w_addr  = TS_ADDR;
        end
      end
      S_REPORT: begin
        // start is not sampled here; it is dropped, not queued.
        w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_stall    <= '0;
      r_read     <= 1'b0;
      r_addr     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_id_ok    <= 1'b0;
      r_ts_ok    <= 1'b0;
      r_timeout  <= 1'b0;
      r_id_value <= '0;
      r_ts_value <= '0;
    end else begin
      r_state    <= w_state;
      r_stall    <= w_stall;
      r_read     <= w_read;
      r_addr     <= w_addr;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_id_ok    <= w_id_ok;
      r_ts_ok    <= w_ts_ok;
      r_timeout  <= w_timeout;
      r_id_value <= w_id_value;
      r_ts_value <= w_ts_value;
    end
  end

  assign address  = r_addr;
  assign read     = r_read;
  assign busy     = r_busy;
  assign done     = r_done;
  assign id_ok    = r_id_ok;
  assign ts_ok    = r_ts_ok;
  assign timeout  = r_timeout;
  assign id_value = r_id_value;
  assign ts_value = r_ts_value;

endmodule

// File: tb/tb_mpsoc_sysid_checker.sv
// Directed bench for mpsoc_sysid_checker (TIMEOUT_CYCLES=4, other defaults).
// A small Avalon slave model stalls each read for a programmed number of
// cycles; a table of vectors gives the expected latency and results.
module tb_mpsoc_sysid_checker;
  localparam int          AW    = 32;
  localparam logic [31:0] EXPTS = 32'd1766737846;
  localparam int          INF   = 1000;

  logic          clock = 1'b0;
  logic          reset_n, start, waitrequest;
  logic [31:0]   readdata;
  logic [AW-1:0] address;
  logic          read, busy, done, id_ok, ts_ok, timeout;
  logic [31:0]   id_value, ts_value;

  mpsoc_sysid_checker #(.TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .address(address),
    .read(read), .waitrequest(waitrequest), .readdata(readdata),
    .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok),
    .timeout(timeout), .id_value(id_value), .ts_value(ts_value));

  always #5 clock = ~clock;

  // Slave model: stall count restarts whenever a transfer ends or read drops.
  int          wait_id, wait_ts;
  logic [31:0] id_data, ts_data;
  int          sl_cnt = 0;
  assign waitrequest = read && (sl_cnt < ((address == 32'h4) ? wait_ts : wait_id));
  assign readdata    = (address == 32'h4) ? ts_data : id_data;
  always @(posedge clock)
    if (!read || !waitrequest) sl_cnt <= 0;
    else                       sl_cnt <= sl_cnt + 1;

  // Monitors (sampled on the falling edge).
  int          cyc = 0;
  int          done_total = 0, rd4_total = 0, unstable_total = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    if (done) done_total <= done_total + 1;
    if (read && address == 32'h4) rd4_total <= rd4_total + 1;
    if (prev_stall && read && address != prev_addr) unstable_total <= unstable_total + 1;
    prev_stall <= read && waitrequest;
    prev_addr  <= address;
  end

  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          w_id, w_ts;
    logic [31:0] d_id, d_ts;
    int          lat;
    logic        e_id_ok, e_ts_ok, e_to;
    logic [31:0] e_idv, e_tsv;
    int          e_rd4;
  } vec_t;

  // Pulse start, wait for done, then check latency and results.
  task automatic run_vec(input vec_t v, input int idx);
    int c0, d0, r0, u0, lat;
    bit seen;
    wait_id = v.w_id; wait_ts = v.w_ts; id_data = v.d_id; ts_data = v.d_ts;
    @(negedge clock);
    d0 = done_total; r0 = rd4_total; u0 = unstable_total; c0 = cyc;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk($sformatf("v%0d read_after_start", idx), read, 1'b1);
    seen = 0; lat = -1;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (done) begin seen = 1; lat = cyc - c0; end
      else @(negedge clock);
    end
    chk($sformatf("v%0d latency", idx), lat, v.lat);
    chk($sformatf("v%0d id_ok", idx), id_ok, v.e_id_ok);
    chk($sformatf("v%0d ts_ok", idx), ts_ok, v.e_ts_ok);
    chk($sformatf("v%0d timeout", idx), timeout, v.e_to);
    chk($sformatf("v%0d id_value", idx), id_value, v.e_idv);
    chk($sformatf("v%0d ts_value", idx), ts_value, v.e_tsv);
    @(negedge clock);
    chk($sformatf("v%0d busy_fall", idx), {busy, read}, 2'b00);
    chk($sformatf("v%0d hold", idx), {id_ok, ts_ok, timeout, id_value, ts_value},
        {v.e_id_ok, v.e_ts_ok, v.e_to, v.e_idv, v.e_tsv});
    repeat (3) @(negedge clock);
    chk($sformatf("v%0d done_count", idx), done_total - d0, 1);
    chk($sformatf("v%0d ts_reads", idx), rd4_total - r0, v.e_rd4);
    chk($sformatf("v%0d addr_stable", idx), unstable_total - u0, 0);
  endtask

  vec_t vt[7];

  initial begin
    int d0, lat;
    bit seen;
    vt[0] = '{0,   0, 32'h0,        EXPTS,        3, 1, 1, 0, 32'h0,        EXPTS,        1};
    vt[1] = '{0,   0, 32'h0,        32'h12345678, 3, 1, 0, 0, 32'h0,        32'h12345678, 1};
    vt[2] = '{3,   3, 32'h0,        EXPTS,        9, 1, 1, 0, 32'h0,        EXPTS,        4};
    vt[3] = '{INF, 0, 32'h0,        EXPTS,        6, 0, 0, 1, 32'h0,        32'h0,        0};
    vt[4] = '{4,   0, 32'h0,        EXPTS,        7, 1, 1, 0, 32'h0,        EXPTS,        1};
    vt[5] = '{0,   5, 32'h0,        EXPTS,        7, 1, 0, 1, 32'h0,        32'h0,        5};
    vt[6] = '{2,   1, 32'hDEADBEEF, EXPTS,        6, 0, 1, 0, 32'hDEADBEEF, EXPTS,        2};

    reset_n = 1'b0; start = 1'b0;
    wait_id = 0; wait_ts = 0; id_data = '0; ts_data = EXPTS;
    repeat (3) @(negedge clock);
    chk("reset_outputs", {read, address, busy, done, id_ok, ts_ok, timeout, id_value, ts_value}, '0);
    reset_n = 1'b1;
    @(negedge clock);

    foreach (vt[i]) run_vec(vt[i], i);

    // Reset while the timestamp read is stalled.
    wait_id = 0; wait_ts = INF; id_data = 32'hCAFE0001; ts_data = EXPTS;
    d0 = done_total;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    @(negedge clock);
    chk("mid_reset_in_rd_ts", {read, address}, {1'b1, 32'h4});
    reset_n = 1'b0;
    @(negedge clock);
    chk("mid_reset_outputs", {read, address, busy, done, id_ok, ts_ok, timeout, id_value, ts_value}, '0);
    reset_n = 1'b1;
    repeat (8) @(negedge clock);
    chk("mid_reset_no_done", done_total - d0, 0);
    run_vec(vt[0], 10);

    // Restart ignored while busy: exactly one done at the unstalled latency.
    run_check_busy_ignore();

    // Start in REPORT ignored; start right after busy falls accepted and clears.
    wait_id = 0; wait_ts = 0; id_data = 32'hDEADBEEF; ts_data = EXPTS;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("b2b_done", done, 1'b1);
    chk("b2b_prev_results", {id_ok, ts_ok, id_value, ts_value}, {1'b0, 1'b1, 32'hDEADBEEF, EXPTS});
    start = 1'b1;                       // edge ends REPORT: must be dropped
    @(negedge clock);
    chk("b2b_report_ignored", {busy, read}, 2'b00);
    id_data = 32'h0;                    // start still high: accepted here
    @(negedge clock);
    start = 1'b0;
    chk("b2b_accepted", {busy, read, address}, {2'b11, 32'h0});
    chk("b2b_cleared", {id_ok, ts_ok, timeout, id_value, ts_value}, '0);
    seen = 0; lat = -1;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (done) begin seen = 1; lat = i; end
      else @(negedge clock);
    end
    chk("b2b_done_seen", lat, 2);
    chk("b2b_results", {id_ok, ts_ok, timeout}, 3'b110);

    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic run_check_busy_ignore();
    int c0, d0, lat;
    bit seen;
    wait_id = 3; wait_ts = 3; id_data = 32'h0; ts_data = EXPTS;
    @(negedge clock);
    d0 = done_total; c0 = cyc;
    start = 1'b1;
    @(negedge clock); start = 1'b0;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    seen = 0; lat = -1;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (done) begin seen = 1; lat = cyc - c0; end
      else @(negedge clock);
    end
    chk("busy_restart_latency", lat, 9);
    repeat (12) @(negedge clock);
    chk("busy_restart_one_done", done_total - d0, 1);
    chk("busy_restart_idle", {busy, read}, 2'b00);
  endtask
endmodule
